// File: rtl/wb_write_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_write_scheduler                                                       |
// | Serialises dual-PE writeback results onto one register-file write port.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wb_write_scheduler #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteW_PE1,
  input  logic [ADDR_W-1:0] RdW_PE1,
  input  logic [DATA_W-1:0] ResultW_PE1,
  input  logic              RegWriteW_PE2,
  input  logic [ADDR_W-1:0] RdW_PE2,
  input  logic [DATA_W-1:0] ResultW_PE2,
  output logic              StallW,
  output logic              RF_WE,
  output logic [ADDR_W-1:0] RF_A3,
  output logic [DATA_W-1:0] RF_WD,
  output logic              Busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_STALL_LVL = CNT_W'(DEPTH - 2);
  localparam logic [PTR_W-1:0] C_PTR_ONE   = PTR_W'(1);

  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic              pe1_ok, pe2_ok, combine, take1, take2, deq;
  logic [1:0]        enq_n;
  logic              slot0_en, slot1_en;
  logic [PTR_W-1:0]  slot0_idx, slot1_idx;
  logic [ADDR_W-1:0] slot0_rd;
  logic [DATA_W-1:0] slot0_data;

  assign Busy   = (count_q != '0);
  assign StallW = (count_q > C_STALL_LVL);
  assign RF_WE  = Busy;
  assign RF_A3  = Busy ? rd_mem[rd_ptr_q]   : '0;
  assign RF_WD  = Busy ? data_mem[rd_ptr_q] : '0;

  always_comb begin
    pe1_ok  = RegWriteW_PE1 && (RdW_PE1 != '0);
    pe2_ok  = RegWriteW_PE2 && (RdW_PE2 != '0);
    // Same destination in one cycle: the younger PE2 result supersedes PE1.
    combine = pe1_ok && pe2_ok && (RdW_PE1 == RdW_PE2);
    take1   = !StallW && pe1_ok && !combine;
    take2   = !StallW && pe2_ok;
    enq_n   = {1'b0, take1} + {1'b0, take2};
    deq     = Busy;

    slot0_en   = take1 || take2;
    slot0_idx  = wr_ptr_q;
    slot0_rd   = take1 ? RdW_PE1     : RdW_PE2;
    slot0_data = take1 ? ResultW_PE1 : ResultW_PE2;
    slot1_en   = take1 && take2;
    slot1_idx  = wr_ptr_q + C_PTR_ONE;

    wr_ptr_d = wr_ptr_q + PTR_W'(enq_n);
    rd_ptr_d = deq ? (rd_ptr_q + C_PTR_ONE) : rd_ptr_q;
    count_d  = count_q + CNT_W'(enq_n) - CNT_W'(deq);
  end

  always_ff @(posedge clk) begin
    if (slot0_en) begin
      rd_mem[slot0_idx]   <= slot0_rd;
      data_mem[slot0_idx] <= slot0_data;
    end
    if (slot1_en) begin
      rd_mem[slot1_idx]   <= RdW_PE2;
      data_mem[slot1_idx] <= ResultW_PE2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_write_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_write_scheduler                                                    |
// | Directed self-checking bench for wb_write_scheduler (DEPTH=4).           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_wb_write_scheduler;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              RegWriteW_PE1, RegWriteW_PE2;
  logic [ADDR_W-1:0] RdW_PE1, RdW_PE2;
  logic [DATA_W-1:0] ResultW_PE1, ResultW_PE2;
  logic              StallW, RF_WE, Busy;
  logic [ADDR_W-1:0] RF_A3;
  logic [DATA_W-1:0] RF_WD;

  int n_checks = 0;
  int n_pass   = 0;
  logic [ADDR_W+DATA_W-1:0] wlog[$];

  wb_write_scheduler #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .RegWriteW_PE1(RegWriteW_PE1), .RdW_PE1(RdW_PE1), .ResultW_PE1(ResultW_PE1),
    .RegWriteW_PE2(RegWriteW_PE2), .RdW_PE2(RdW_PE2), .ResultW_PE2(ResultW_PE2),
    .StallW(StallW), .RF_WE(RF_WE), .RF_A3(RF_A3), .RF_WD(RF_WD), .Busy(Busy)
  );

  always #5 clk = ~clk;

  // Every write the register file would commit on the following rising edge.
  always @(negedge clk) if (rst && RF_WE) wlog.push_back({RF_A3, RF_WD});

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v1, input int a1, input int d1,
                       input int v2, input int a2, input int d2);
    RegWriteW_PE1 = (v1 != 0);
    RdW_PE1       = ADDR_W'(a1);
    ResultW_PE1   = DATA_W'(d1);
    RegWriteW_PE2 = (v2 != 0);
    RdW_PE2       = ADDR_W'(a2);
    ResultW_PE2   = DATA_W'(d2);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    drive(1, 3, 32'h1234, 1, 4, 32'h5678);
    #2;
    n_checks++; if (RF_WE !== 1'b0) $display("FAIL reset_we got %0b exp 0", RF_WE); else n_pass++;
    n_checks++; if (StallW !== 1'b0) $display("FAIL reset_stall got %0b exp 0", StallW); else n_pass++;
    n_checks++; if (Busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", Busy); else n_pass++;
    n_checks++; if ({RF_A3, RF_WD} !== '0) $display("FAIL reset_a3_wd got %0h/%0h exp 0/0", RF_A3, RF_WD); else n_pass++;
    step();
    step();
    idle();
    rst = 1'b1;
    step();
    n_checks++; if (Busy !== 1'b0) $display("FAIL reset_nothing_queued busy got %0b exp 0", Busy); else n_pass++;
  endtask

  task automatic test_single();
    wlog.delete();
    drive(1, 3, 32'hA5A5_0001, 0, 0, 0);
    step();
    idle();
    n_checks++; if (RF_WE !== 1'b1) $display("FAIL single_we got %0b exp 1", RF_WE); else n_pass++;
    n_checks++; if (RF_A3 !== ADDR_W'(3)) $display("FAIL single_a3 got %0d exp 3", RF_A3); else n_pass++;
    n_checks++; if (RF_WD !== 32'hA5A5_0001) $display("FAIL single_wd got %0h exp a5a50001", RF_WD); else n_pass++;
    step();
    n_checks++; if (Busy !== 1'b0) $display("FAIL single_busy_after got %0b exp 0", Busy); else n_pass++;
    n_checks++; if (RF_WE !== 1'b0) $display("FAIL single_we_after got %0b exp 0", RF_WE); else n_pass++;
  endtask

  task automatic test_pair();
    drive(1, 4, 32'h11, 1, 5, 32'h22);
    step();
    idle();
    n_checks++; if ({RF_WE, RF_A3, RF_WD} !== {1'b1, 5'd4, 32'h11}) $display("FAIL pair_first got %0b/%0d/%0h exp 1/4/11", RF_WE, RF_A3, RF_WD); else n_pass++;
    n_checks++; if (StallW !== 1'b0) $display("FAIL pair_stall got %0b exp 0", StallW); else n_pass++;
    step();
    n_checks++; if ({RF_WE, RF_A3, RF_WD} !== {1'b1, 5'd5, 32'h22}) $display("FAIL pair_second got %0b/%0d/%0h exp 1/5/22", RF_WE, RF_A3, RF_WD); else n_pass++;
    step();
    n_checks++; if (Busy !== 1'b0) $display("FAIL pair_busy_after got %0b exp 0", Busy); else n_pass++;
  endtask

  task automatic test_combine_x0();
    wlog.delete();
    drive(1, 7, 32'h1, 1, 7, 32'h2);
    step();
    idle();
    step();
    step();
    n_checks++; if (wlog.size() != 1) $display("FAIL combine_count got %0d exp 1", wlog.size());
    else if (wlog[0] !== {5'd7, 32'h2}) $display("FAIL combine_entry got %0h exp %0h", wlog[0], {5'd7, 32'h2});
    else n_pass++;
    wlog.delete();
    drive(1, 0, 32'h33, 1, 9, 32'h99);
    step();
    idle();
    step();
    step();
    n_checks++; if (wlog.size() != 1) $display("FAIL x0_count got %0d exp 1", wlog.size());
    else if (wlog[0] !== {5'd9, 32'h99}) $display("FAIL x0_entry got %0h exp %0h", wlog[0], {5'd9, 32'h99});
    else n_pass++;
  endtask

  // Pairs every cycle; junk pairs (Rd 30/31) are offered while stalled.
  task automatic test_stall_full();
    int   seq_rd[6]    = '{10, 12, 30, 14, 30, 16};
    logic exp_stall[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    wlog.delete();
    for (int i = 0; i < 6; i++) begin
      drive(1, seq_rd[i], 32'h100 + seq_rd[i], 1, seq_rd[i] + 1, 32'h100 + seq_rd[i] + 1);
      step();
      n_checks++; if (StallW !== exp_stall[i]) $display("FAIL stall_step%0d got %0b exp %0b", i, StallW, exp_stall[i]); else n_pass++;
    end
    idle();
    repeat (5) step();
    n_checks++; if (Busy !== 1'b0) $display("FAIL stall_drained busy got %0b exp 0", Busy); else n_pass++;
    n_checks++; if (wlog.size() != 8) $display("FAIL stall_count got %0d exp 8", wlog.size()); else n_pass++;
    for (int k = 0; k < 8 && k < wlog.size(); k++) begin
      n_checks++;
      if (wlog[k] !== {ADDR_W'(10 + k), DATA_W'(32'h100 + 10 + k)})
        $display("FAIL stall_order[%0d] got %0h exp %0h", k, wlog[k], {ADDR_W'(10 + k), DATA_W'(32'h100 + 10 + k)});
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    wlog.delete();
    for (int i = 1; i <= 10; i++) begin
      drive(1, i, 32'hB000 + i, 0, 0, 0);
      step();
      n_checks++;
      if ({StallW, RF_WE, RF_A3, RF_WD} !== {1'b0, 1'b1, ADDR_W'(i), DATA_W'(32'hB000 + i)})
        $display("FAIL b2b[%0d] got stall=%0b we=%0b a3=%0d wd=%0h exp 0/1/%0d/%0h",
                 i, StallW, RF_WE, RF_A3, RF_WD, i, 32'hB000 + i);
      else n_pass++;
    end
    idle();
    step();
    n_checks++; if (Busy !== 1'b0) $display("FAIL b2b_busy_after got %0b exp 0", Busy); else n_pass++;
    n_checks++; if (wlog.size() != 10) $display("FAIL b2b_count got %0d exp 10", wlog.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    drive(1, 20, 32'h20, 1, 21, 32'h21);
    step();
    drive(1, 22, 32'h22, 1, 23, 32'h23);
    step();
    idle();
    n_checks++; if (StallW !== 1'b1) $display("FAIL middrain_prefill_stall got %0b exp 1", StallW); else n_pass++;
    wlog.delete();
    #1;
    rst = 1'b0;
    #1;
    n_checks++; if ({RF_WE, StallW, Busy} !== 3'b000) $display("FAIL middrain_reset got we/stall/busy=%0b%0b%0b exp 000", RF_WE, StallW, Busy); else n_pass++;
    step();
    rst = 1'b1;
    repeat (5) step();
    n_checks++; if (wlog.size() != 0) $display("FAIL middrain_writes got %0d exp 0", wlog.size()); else n_pass++;
    n_checks++; if (Busy !== 1'b0) $display("FAIL middrain_busy got %0b exp 0", Busy); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1);
  end

  initial begin
    idle();
    test_reset();
    test_single();
    test_pair();
    test_combine_x0();
    test_stall_full();
    test_back_to_back();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_write_scheduler.md
Name: wb_write_scheduler

Overview:
- Serialises the two per-PE writeback results (PE1, PE2) onto the single register-file write port.
- Sits between the dual-PE writeback stage and the register file.
- Buffers up to DEPTH pending writes in program order (PE1 older than PE2 within a cycle).
- Drains one write per cycle and stalls the writeback stage when the buffer cannot take a full pair.

Parameters:
DEPTH, 4, buffer entries; power of two, >= 2
DATA_W, 32, result width
ADDR_W, 5, destination register index width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
RegWriteW_PE1  input  1  PE1 writeback request valid
RdW_PE1  input  ADDR_W  PE1 destination register
ResultW_PE1  input  DATA_W  PE1 writeback result
RegWriteW_PE2  input  1  PE2 writeback request valid
RdW_PE2  input  ADDR_W  PE2 destination register
ResultW_PE2  input  DATA_W  PE2 writeback result
StallW  output  1  writeback stage must hold; requests ignored while high
RF_WE  output  1  register-file write enable
RF_A3  output  ADDR_W  register-file write address
RF_WD  output  DATA_W  register-file write data
Busy  output  1  buffer non-empty

Behaviour:
- Reset (rst low, asynchronous):
  - read pointer, write pointer and count cleared to 0.
  - RF_WE=0, RF_A3=0, RF_WD=0, StallW=0, Busy=0.
  - Buffer contents are don't-care.
  - Pending writes are discarded, including when reset is asserted mid-drain.
- Storage: circular buffer of DEPTH entries {rd, data}; count width clog2(DEPTH)+1.
- StallW = (count > DEPTH-2), taken from the registered count only. It is conservative and ignores a same-cycle dequeue.
- Enqueue (edge N, only when StallW=0):
  - Filtering: a request with Rd=0 is dropped (x0 writes are never queued).
  - Write-combining: if both requests are valid, both Rd nonzero, and RdW_PE1==RdW_PE2, only the PE2 entry is enqueued (PE2 is younger and overwrites PE1).
  - Otherwise PE1 is written at wr_ptr, then PE2 at wr_ptr+1 (or at wr_ptr if PE1 was not enqueued). 0, 1 or 2 entries per edge.
  - wr_ptr advances by the number enqueued, modulo DEPTH.
- Requests presented while StallW=1 are ignored (not enqueued). Upstream holds them.
- Drain:
  - RF_WE = (count != 0); RF_A3/RF_WD = head entry when count != 0, else 0. All combinational from registered state.
  - The register file samples at the next edge. On that edge rd_ptr advances by 1 modulo DEPTH and count decrements.
- Latency: an entry enqueued at edge N with an empty buffer is presented during cycle N..N+1 and written at edge N+1.
- Simultaneous enqueue and dequeue on the same edge: count_next = count + enq_n - deq. Never overflows, because enqueue requires count <= DEPTH-2.
- Ordering: strict program order across both PEs and across cycles; no reordering.
- Busy = (count != 0).
- Pointer wrap at DEPTH-1 -> 0 on both pointers, including a two-entry enqueue that straddles the wrap.

Test Plan:
- Reset:
  - Stimulus: assert rst=0 with arbitrary inputs; also assert rst=0 mid-drain with 3 entries queued.
  - Required: RF_WE=0, StallW=0, Busy=0 immediately; no further RF writes after release.
- Single write:
  - Stimulus: PE1 only, Rd=3, data 0xA5A5_0001, one cycle.
  - Required: RF_WE=1, RF_A3=3, RF_WD=0xA5A5_0001 in the next cycle; Busy returns 0 after that edge.
- Pair ordering:
  - Stimulus: PE1 Rd=4/0x11 and PE2 Rd=5/0x22 in the same cycle.
  - Required: writes (4,0x11) then (5,0x22) on consecutive edges.
- Combine and x0 filtering:
  - Stimulus: PE1 Rd=7/0x1, PE2 Rd=7/0x2.
    - Required: exactly one write, (7,0x2).
  - Stimulus: PE1 Rd=0 with PE2 Rd=9.
    - Required: only (9,...) is written.
- Stall and full:
  - Stimulus: pairs every cycle, DEPTH=4.
  - Required:
    - StallW=1 once count reaches 3.
    - Requests during stall produce no writes.
    - After release, the 8-entry sequence appears in order with no loss or duplication.
    - Pointers wrap correctly.
- Back-to-back throughput:
  - Stimulus: a single PE1 write every cycle for 10 cycles.
  - Required: StallW stays 0; 10 writes on 10 consecutive edges starting one edge after the first request.
